full_adder_pipe: RTL and testbench

//  WIDTH-bit ripple-carry adder: s = a + b + cin, carry-out on c.

---
 rtl/full_adder_pipe.sv | 111 +++++++++++
 tb/tb_full_adder_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_pipe.sv
// Purpose: WIDTH-bit ripple-carry adder {c,s} = a + b + cin, built from chained 1-bit cells.
// Latency: 1 clk when REG_OUT=1; s/c are combinational when REG_OUT=0. out_valid is always registered.
// Backpressure: none. A new operand set is accepted on every in_valid cycle.
// Optional flags (ovf, zero) are present only when FULL_ADDER_FLAGS_EN is defined.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic k_in,
    output logic s,
    output logic k_out
);
    assign s     = a ^ b ^ k_in;
    assign k_out = (a & b) | (a & k_in) | (b & k_in);
endmodule

module full_adder_pipe #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c,
`ifdef FULL_ADDER_FLAGS_EN
    output logic             ovf,
    output logic             zero,
`endif
    output logic             out_valid
);

    // Carry chain: k[0] is the carry-in, k[WIDTH] is the carry-out of the MSB.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum_comb;

    assign k[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .k_in  (k[i]),
            .s     (sum_comb[i]),
            .k_out (k[i+1])
        );
    end

`ifdef FULL_ADDER_FLAGS_EN
    // Signed overflow: operands share a sign but the result sign differs.
    logic ovf_comb;
    logic zero_comb;
    assign ovf_comb  = (a[WIDTH-1] == b[WIDTH-1]) & (sum_comb[WIDTH-1] != a[WIDTH-1]);
    assign zero_comb = ~|sum_comb;
`endif

    // Valid tracks the input qualifier one cycle later; reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] s_q;
        logic             c_q;
`ifdef FULL_ADDER_FLAGS_EN
        logic             ovf_q;
        logic             zero_q;
`endif

        // Result registers load only on qualified inputs, so idle-cycle X on a/b/cin never lands here.
        always_ff @(posedge clk) begin
            if (rst) begin
                s_q    <= '0;
                c_q    <= 1'b0;
`ifdef FULL_ADDER_FLAGS_EN
                ovf_q  <= 1'b0;
                zero_q <= 1'b0;
`endif
            end else if (in_valid) begin
                s_q    <= sum_comb;
                c_q    <= k[WIDTH];
`ifdef FULL_ADDER_FLAGS_EN
                ovf_q  <= ovf_comb;
                zero_q <= zero_comb;
`endif
            end
        end

        assign s    = s_q;
        assign c    = c_q;
`ifdef FULL_ADDER_FLAGS_EN
        assign ovf  = ovf_q;
        assign zero = zero_q;
`endif
    end else begin : g_comb
        assign s    = sum_comb;
        assign c    = k[WIDTH];
`ifdef FULL_ADDER_FLAGS_EN
        assign ovf  = ovf_comb;
        assign zero = zero_comb;
`endif
    end

endmodule

// File: tb/tb_full_adder_pipe.sv
// Bench for full_adder_pipe: three instances (W1 registered, W8 registered, W1 combinational).
// Expected results come from a behavioural add pushed to a scoreboard queue at drive time.
// Flag checks are compiled in only when FULL_ADDER_FLAGS_EN is defined.

module tb_full_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=1, REG_OUT=1
    logic       v1, ci1, c1, ov1;
    logic [0:0] a1, b1, s1;
    // WIDTH=8, REG_OUT=1
    logic       v8, ci8, c8, ov8;
    logic [7:0] a8, b8, s8;
    // WIDTH=1, REG_OUT=0
    logic       v0, ci0, c0, ov0;
    logic [0:0] a0, b0, s0;

`ifdef FULL_ADDER_FLAGS_EN
    logic f1_ovf, f1_zero, f8_ovf, f8_zero, f0_ovf, f0_zero;
`endif

    full_adder_pipe #(.WIDTH(1), .REG_OUT(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
        .s(s1), .c(c1),
`ifdef FULL_ADDER_FLAGS_EN
        .ovf(f1_ovf), .zero(f1_zero),
`endif
        .out_valid(ov1)
    );

    full_adder_pipe #(.WIDTH(8), .REG_OUT(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
        .s(s8), .c(c8),
`ifdef FULL_ADDER_FLAGS_EN
        .ovf(f8_ovf), .zero(f8_zero),
`endif
        .out_valid(ov8)
    );

    full_adder_pipe #(.WIDTH(1), .REG_OUT(0)) u_w0 (
        .clk(clk), .rst(rst), .in_valid(v0), .a(a0), .b(b0), .cin(ci0),
        .s(s0), .c(c0),
`ifdef FULL_ADDER_FLAGS_EN
        .ovf(f0_ovf), .zero(f0_zero),
`endif
        .out_valid(ov0)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboards: w1 entries are {c,s}; w8 entries are {zero,ovf,c,s[7:0]}.
    logic [1:0]  q1[$];
    logic [10:0] q8[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one W1 operand set, then compare its result one edge later.
    task automatic step1(input logic a, input logic b, input logic ci);
        logic [1:0] exp;
        v1 = 1'b1; a1 = a; b1 = b; ci1 = ci;
        q1.push_back(2'({1'b0, a}) + 2'({1'b0, b}) + 2'({1'b0, ci}));
        tick();
        chk("w1_vld", 64'(ov1), 64'(1'b1));
        if (q1.size() == 0) begin
            chk("w1_sb_empty", 64'(0), 64'(1));
        end else begin
            exp = q1.pop_front();
            chk("w1_cs", 64'({c1, s1}), 64'(exp));
        end
    endtask

    // Drive one W8 operand set, then compare sum, carry and flags one edge later.
    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0]  sum;
        logic        ovf, zero;
        logic [10:0] exp;
        v8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
        sum  = 9'({1'b0, a}) + 9'({1'b0, b}) + 9'(ci);
        ovf  = (a[7] == b[7]) && (sum[7] != a[7]);
        zero = (sum[7:0] == 8'h00);
        q8.push_back({zero, ovf, sum});
        tick();
        chk("w8_vld", 64'(ov8), 64'(1'b1));
        if (q8.size() == 0) begin
            chk("w8_sb_empty", 64'(0), 64'(1));
        end else begin
            exp = q8.pop_front();
            chk("w8_cs", 64'({c8, s8}), 64'(exp[8:0]));
`ifdef FULL_ADDER_FLAGS_EN
            chk("w8_ovf", 64'(f8_ovf), 64'(exp[9]));
            chk("w8_zero", 64'(f8_zero), 64'(exp[10]));
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; ci1 = 0;
        v8 = 0; a8 = 0; b8 = 0; ci8 = 0;
        v0 = 0; a0 = 0; b0 = 0; ci0 = 0;
        tick();
        tick();

        // Reset state
        chk("rst_w1_cs", 64'({c1, s1}), 64'(0));
        chk("rst_w1_vld", 64'(ov1), 64'(0));
        chk("rst_w8_cs", 64'({c8, s8}), 64'(0));
        chk("rst_w8_vld", 64'(ov8), 64'(0));
        chk("rst_w0_vld", 64'(ov0), 64'(0));
`ifdef FULL_ADDER_FLAGS_EN
        chk("rst_w8_ovf", 64'(f8_ovf), 64'(0));
        chk("rst_w8_zero", 64'(f8_zero), 64'(0));
`endif
        rst = 1'b0;

        // W1 truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            step1(abc[2], abc[1], abc[0]);
        end

        // Idle with X operands: result holds at last value (1+1+1 -> c=1,s=1), valid drops
        v1 = 1'b0; a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx;
        tick();
        chk("w1_hold_vld", 64'(ov1), 64'(0));
        chk("w1_hold_cs", 64'({c1, s1}), 64'(2'b11));
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        tick();
        chk("w1_hold2_cs", 64'({c1, s1}), 64'(2'b11));

        // W8 directed boundaries plus a few random operands
        step8(8'hFF, 8'h01, 1'b0);
        step8(8'h7F, 8'h01, 1'b0);
        step8(8'hFF, 8'hFF, 1'b1);
        step8(8'h00, 8'h00, 1'b0);
        step8(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // Valid pulse then idle with changing operands: hold, valid 1 then 0
        step8(8'h12, 8'h34, 1'b1);
        v8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
        tick();
        chk("w8_idle_vld", 64'(ov8), 64'(0));
        chk("w8_idle_cs", 64'({c8, s8}), 64'(9'h047));
        a8 = 8'h01; b8 = 8'hF0;
        tick();
        chk("w8_idle2_cs", 64'({c8, s8}), 64'(9'h047));

        // Reset wins over a simultaneous valid input
        rst = 1'b1; v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b1;
        tick();
        chk("w8_rstv_cs", 64'({c8, s8}), 64'(0));
        chk("w8_rstv_vld", 64'(ov8), 64'(0));
        rst = 1'b0;
        // First valid after reset appears one cycle later
        step8(8'h02, 8'h03, 1'b0);
        v8 = 1'b0;

        // Combinational variant: result visible before the edge, valid registered
        v0 = 1'b1; a0 = 1'b1; b0 = 1'b0; ci0 = 1'b1;
        #1;
        chk("w0_cs_comb", 64'({c0, s0}), 64'(2'b10));
        chk("w0_vld_pre", 64'(ov0), 64'(0));
        tick();
        chk("w0_vld_post", 64'(ov0), 64'(1));
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            a0 = abc[2]; b0 = abc[1]; ci0 = abc[0];
            #1;
            chk("w0_tt", 64'({c0, s0}), 64'(2'({1'b0, abc[2]}) + 2'({1'b0, abc[1]}) + 2'({1'b0, abc[0]})));
        end
        v0 = 1'b0;
        tick();
        chk("w0_vld_drop", 64'(ov0), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
